// File: rtl/control_v2_if.sv
// Control-unit bus: decode-side instruction inputs and PC/regfile-side strobes.
//   master : drives instr_valid, contl, target, pc_ret, zero_flag, carry_flag, err_clr
//   slave  : drives jump1, ret1, push1, wen1, jump_addr, squashing, stk_ovf, stk_unf
interface control_v2_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              instr_valid;
  logic [3:0]        contl;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_ret;
  logic              zero_flag;
  logic              carry_flag;
  logic              err_clr;
  logic              jump1;
  logic              ret1;
  logic              push1;
  logic              wen1;
  logic [ADDR_W-1:0] jump_addr;
  logic              squashing;
  logic              stk_ovf;
  logic              stk_unf;

  modport master (
    output instr_valid, contl, target, pc_ret, zero_flag, carry_flag, err_clr,
    input  jump1, ret1, push1, wen1, jump_addr, squashing, stk_ovf, stk_unf
  );

  modport slave (
    input  instr_valid, contl, target, pc_ret, zero_flag, carry_flag, err_clr,
    output jump1, ret1, push1, wen1, jump_addr, squashing, stk_ovf, stk_unf
  );
endinterface

// File: rtl/control_v2.sv
// Second-generation pipeline control unit: decodes the 4-bit control field into
// registered jump/return/push/write strobes, evaluates zero/carry conditions,
// keeps a saturating return-address stack and squashes the branch shadow.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : control_v2_if.slave (instruction inputs, strobes, error flags)
module control_v2 #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned STACK_DEPTH  = 4,
  parameter int unsigned SQUASH_SLOTS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  control_v2_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH) + 1;
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned CNT_W = (SQUASH_SLOTS > 0) ? $clog2(SQUASH_SLOTS + 1) : 1;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_RET  = 3'd1,
    OP_JMP  = 3'd2,
    OP_CALL = 3'd3,
    OP_JZ   = 3'd4,
    OP_JNZ  = 3'd5,
    OP_JC   = 3'd6,
    OP_JNC  = 3'd7
  } op_e;

  logic              r_jump1;
  logic              r_ret1;
  logic              r_push1;
  logic              r_wen1;
  logic [ADDR_W-1:0] r_jump_addr;
  logic              r_stk_ovf;
  logic              r_stk_unf;
  logic [PTR_W-1:0]  r_sp;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

  logic              w_jump;
  logic              w_ret;
  logic              w_push;
  logic              w_wen;
  logic [ADDR_W-1:0] w_addr;
  logic [PTR_W-1:0]  w_sp;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_ovf_set;
  logic              w_unf_set;
  logic              w_empty;
  logic              w_full;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [ADDR_W-1:0] w_top;

  assign w_empty  = (r_sp == '0);
  assign w_full   = (r_sp == PTR_W'(STACK_DEPTH));
  assign w_wr_idx = IDX_W'(r_sp);
  assign w_rd_idx = IDX_W'(r_sp - PTR_W'(1));
  assign w_top    = r_stack[w_rd_idx];

  // Next-state decode of the effective instruction
  always_comb begin
    w_jump    = 1'b0;
    w_ret     = 1'b0;
    w_push    = 1'b0;
    w_wen     = 1'b0;
    w_addr    = r_jump_addr;
    w_sp      = r_sp;
    w_cnt     = r_cnt;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;

    if (bus.instr_valid && (r_cnt != '0)) begin
      // Branch shadow: drop the instruction, consume one slot
      w_cnt = r_cnt - CNT_W'(1);
    end else if (bus.instr_valid) begin
      if (bus.contl[3]) begin
        w_wen = 1'b1;
      end else begin
        unique case (op_e'(bus.contl[2:0]))
          OP_NOP: ;
          OP_RET: begin
            if (!w_empty) begin
              w_jump = 1'b1;
              w_ret  = 1'b1;
              w_addr = w_top;
              w_sp   = r_sp - PTR_W'(1);
            end else begin
              w_unf_set = 1'b1;
            end
          end
          OP_JMP: begin
            w_jump = 1'b1;
            w_addr = bus.target;
          end
          OP_CALL: begin
            w_jump = 1'b1;
            w_addr = bus.target;
            if (!w_full) begin
              w_push = 1'b1;
              w_sp   = r_sp + PTR_W'(1);
            end else begin
              w_ovf_set = 1'b1;
            end
          end
          OP_JZ: begin
            w_jump = bus.zero_flag;
            if (bus.zero_flag) w_addr = bus.target;
          end
          OP_JNZ: begin
            w_jump = !bus.zero_flag;
            if (!bus.zero_flag) w_addr = bus.target;
          end
          OP_JC: begin
            w_jump = bus.carry_flag;
            if (bus.carry_flag) w_addr = bus.target;
          end
          OP_JNC: begin
            w_jump = !bus.carry_flag;
            if (!bus.carry_flag) w_addr = bus.target;
          end
          default: ;
        endcase
      end
      if (w_jump) w_cnt = CNT_W'(SQUASH_SLOTS);
    end
  end

  // Registered strobes, pointer, squash counter and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_jump1     <= 1'b0;
      r_ret1      <= 1'b0;
      r_push1     <= 1'b0;
      r_wen1      <= 1'b0;
      r_jump_addr <= '0;
      r_stk_ovf   <= 1'b0;
      r_stk_unf   <= 1'b0;
      r_sp        <= '0;
      r_cnt       <= '0;
    end else begin
      r_jump1     <= w_jump;
      r_ret1      <= w_ret;
      r_push1     <= w_push;
      r_wen1      <= w_wen;
      r_jump_addr <= w_addr;
      // A new error in the clearing cycle keeps the flag set
      r_stk_ovf   <= w_ovf_set | (r_stk_ovf & ~bus.err_clr);
      r_stk_unf   <= w_unf_set | (r_stk_unf & ~bus.err_clr);
      r_sp        <= w_sp;
      r_cnt       <= w_cnt;
    end
  end

  // Stack storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (w_push) r_stack[w_wr_idx] <= bus.pc_ret;
  end

  assign bus.jump1     = r_jump1;
  assign bus.ret1      = r_ret1;
  assign bus.push1     = r_push1;
  assign bus.wen1      = r_wen1;
  assign bus.jump_addr = r_jump_addr;
  assign bus.squashing = (r_cnt != '0);
  assign bus.stk_ovf   = r_stk_ovf;
  assign bus.stk_unf   = r_stk_unf;

endmodule
